// File: rtl/multitap_sms_n_pkg.sv
// Shared types and constants for the SMS multitap.
// Optional TH filter is enabled with MULTITAP_TH_FILTER_EN.
package multitap_pkg;
   localparam int PAD_W           = 6;
   localparam int PORT_W          = 7;
   localparam int TH_BIT          = 6;
   localparam int TMR_W           = 24;
   localparam int TMR_MAX_DEFAULT = 57000 * 15;

   typedef struct packed {
      logic b;
      logic a;
      logic right;
      logic left;
      logic down;
      logic up;
   } pad_t;

   typedef enum logic {
      ST_SCAN    = 1'b0,
      ST_TIMEOUT = 1'b1
   } state_t;

   // Host-driven bits pass through; device bits carry active-low buttons with TH read as 1.
   function automatic logic [PORT_W-1:0] resolve_port(
      input logic [PORT_W-1:0] port_in,
      input logic [PORT_W-1:0] port_dir,
      input pad_t              sel
   );
      return (~port_dir & port_in) | (port_dir & {1'b1, ~sel});
   endfunction
endpackage

// File: rtl/multitap_sms_n_if.sv
// Pad and port bundle between the controller block / host port and the multitap.
interface multitap_sms_n_if #(
   parameter int NUM_PADS = 4
) ();
   import multitap_pkg::*;
   localparam int IDX_W = $clog2(NUM_PADS);

   logic [PAD_W*NUM_PADS-1:0] pad_in;
   logic [NUM_PADS-1:0]       pad_present;
   logic [PORT_W-1:0]         port_in;
   logic [PORT_W-1:0]         port_dir;
   logic [PORT_W-1:0]         port_out;
   logic [IDX_W-1:0]          pad_idx;
   logic                      timeout;

   modport master (
      output pad_in, pad_present, port_in, port_dir,
      input  port_out, pad_idx, timeout
   );

   modport slave (
      input  pad_in, pad_present, port_in, port_dir,
      output port_out, pad_idx, timeout
   );
endinterface

// File: rtl/multitap_sms_n_th_filter.sv
// TH glitch filter: output follows input only after FILT_LEN consecutive differing clocks.
// Built only when MULTITAP_TH_FILTER_EN is defined.
`ifdef MULTITAP_TH_FILTER_EN
module multitap_th_filter #(
   parameter int FILT_LEN = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);
   localparam int CNT_W = $clog2(FILT_LEN + 1);

   logic             q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q   <= 1'b1;
         cnt_q <= '0;
      end else begin
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   // Any sample matching the current output restarts the stability count.
   always_comb begin
      q_d   = q_q;
      cnt_d = '0;
      if (d != q_q) begin
         if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
            q_d = d;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign q = q_q;
endmodule
`endif

// File: rtl/multitap_sms_n.sv
// SMS-style multitap: TH falling edges step through NUM_PADS pads, TH idle high times out to pad 0.
// MULTITAP_TH_FILTER_EN inserts a FILT_LEN-clock TH filter ahead of the edge detector.
module multitap_sms_n
   import multitap_pkg::*;
#(
   parameter int NUM_PADS = 4,
   parameter int TMR_MAX  = TMR_MAX_DEFAULT,
   parameter int FILT_LEN = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   multitap_sms_n_if.slave  bus
);
   localparam int                 IDX_W     = $clog2(NUM_PADS);
   localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_PADS - 1);
   localparam logic [TMR_W-1:0]   TMR_MAX_C = TMR_W'(TMR_MAX);

   if (NUM_PADS < 2 || NUM_PADS > 8 || FILT_LEN < 1) begin : g_bad_param
      $error("multitap_sms_n: NUM_PADS must be 2..8 and FILT_LEN >= 1");
   end

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             th_q, th_d;
   logic             th;
   logic             th_f;
   logic             fe;
   pad_t             sel;
   pad_t             pads [NUM_PADS];

   // An undriven TH line floats high.
   assign th = bus.port_dir[TH_BIT] | bus.port_in[TH_BIT];

`ifdef MULTITAP_TH_FILTER_EN
   multitap_th_filter #(
      .FILT_LEN (FILT_LEN)
   ) u_th_filter (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (th),
      .q       (th_f)
   );
`else
   assign th_f = th;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_TIMEOUT;
         idx_q   <= '0;
         tmr_q   <= '0;
         th_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tmr_q   <= tmr_d;
         th_q    <= th_d;
      end
   end

   // A falling edge always takes priority over an expiring timer.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tmr_d   = tmr_q;
      th_d    = th_f;
      fe      = th_q & ~th_f;

      if (fe) begin
         tmr_d = '0;
      end else if (th_f && (tmr_q != TMR_MAX_C)) begin
         tmr_d = tmr_q + TMR_W'(1);
      end

      case (state_q)
         ST_SCAN: begin
            if (fe) begin
               idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else if (th_f && (tmr_q == TMR_MAX_C)) begin
               state_d = ST_TIMEOUT;
               idx_d   = '0;
            end
         end
         ST_TIMEOUT: begin
            if (fe) begin
               state_d = ST_SCAN;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = ST_TIMEOUT;
            idx_d   = '0;
         end
      endcase
   end

   for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      assign pads[gi] = bus.pad_present[gi] ? pad_t'(bus.pad_in[PAD_W*gi +: PAD_W]) : pad_t'('0);
   end

   assign sel          = pads[idx_q];
   assign bus.port_out = resolve_port(bus.port_in, bus.port_dir, sel);
   assign bus.pad_idx  = idx_q;
   assign bus.timeout  = (state_q == ST_TIMEOUT);
endmodule

// File: tb/tb_multitap_sms_n.sv
// Directed bench: a 4-pad and a 3-pad multitap share one TH/port stimulus.
module tb_multitap_sms_n;
   localparam int TMR_MAX  = 20;
   localparam int FILT_LEN = 4;
`ifdef MULTITAP_TH_FILTER_EN
   localparam int HIGH_PRE = 0;
`else
   localparam int HIGH_PRE = 4;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [6:0] port_in;
   logic [6:0] port_dir;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   multitap_sms_n_if #(.NUM_PADS(4)) bus4 ();
   multitap_sms_n_if #(.NUM_PADS(3)) bus3 ();

   assign bus4.port_in  = port_in;
   assign bus4.port_dir = port_dir;
   assign bus3.port_in  = port_in;
   assign bus3.port_dir = port_dir;

   multitap_sms_n #(.NUM_PADS(4), .TMR_MAX(TMR_MAX), .FILT_LEN(FILT_LEN)) dut4 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus4)
   );

   multitap_sms_n #(.NUM_PADS(3), .TMR_MAX(TMR_MAX), .FILT_LEN(FILT_LEN)) dut3 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s got=%0h", tag, got);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One TH pulse: 4 clocks low then 4 clocks high; TH driven by host (port_dir[6]=0).
   task automatic th_pulse();
      port_in[6] = 1'b0;
      tick(4);
      port_in[6] = 1'b1;
      tick(4);
   endtask

   int exp4 [5] = '{0, 1, 2, 3, 0};
   int exp3 [5] = '{0, 1, 2, 0, 1};

   initial begin
      port_in          = 7'h00;
      port_dir         = 7'h7F;
      bus4.pad_in      = {6'h00, 6'h00, 6'h00, 6'h01};
      bus4.pad_present = 4'b1111;
      bus3.pad_in      = 18'h0;
      bus3.pad_present = 3'b111;

      #2 reset_n = 1'b0;
      #1;
      check("reset_idx4", 32'(bus4.pad_idx), 0);
      check("reset_tmo4", 32'(bus4.timeout), 1);
      check("reset_tmo3", 32'(bus3.timeout), 1);
      tick(2);
      reset_n = 1'b1;

      tick(10);
      check("idle_idx4", 32'(bus4.pad_idx), 0);
      check("idle_tmo4", 32'(bus4.timeout), 1);
      check("pad0_up_out", 32'(bus4.port_out), 32'h7E);

      port_dir = 7'h3F;
      port_in  = 7'h40;
      tick(1);
      check("th_host_out", 32'(bus4.port_out), 32'h7E);

      for (int p = 0; p < 5; p++) begin
         th_pulse();
         check($sformatf("pulse%0d_idx4", p), 32'(bus4.pad_idx), 32'(exp4[p]));
         check($sformatf("pulse%0d_idx3", p), 32'(bus3.pad_idx), 32'(exp3[p]));
      end
      check("scan_tmo4", 32'(bus4.timeout), 0);

      tick(TMR_MAX - HIGH_PRE);
      check("tmr_max_tmo4", 32'(bus4.timeout), 0);
      check("tmr_max_tmo3", 32'(bus3.timeout), 0);
      tick(1);
      check("expire_tmo4", 32'(bus4.timeout), 1);
      check("expire_idx4", 32'(bus4.pad_idx), 0);
      check("expire_tmo3", 32'(bus3.timeout), 1);
      check("expire_idx3", 32'(bus3.pad_idx), 0);

      bus4.pad_present = 4'b1011;
      bus4.pad_in      = {6'h20, 6'h3F, 6'h00, 6'h01};
      th_pulse();
      check("rescan_idx4", 32'(bus4.pad_idx), 0);
      check("rescan_out4", 32'(bus4.port_out), 32'h7E);
      th_pulse();
      check("pad1_out4", 32'(bus4.port_out), 32'h7F);
      th_pulse();
      check("pad2_idx4", 32'(bus4.pad_idx), 2);
      check("pad2_absent", 32'(bus4.port_out[5:0]), 32'h3F);
      th_pulse();
      check("pad3_b", 32'(bus4.port_out[5:0]), 32'h1F);

      th_pulse();
      th_pulse();
      th_pulse();
      check("mid_idx4", 32'(bus4.pad_idx), 2);
      port_dir = 7'h00;
      port_in  = 7'h55;
      tick(1);
      check("pass_out4", 32'(bus4.port_out), 32'h55);
      check("pass_out3", 32'(bus3.port_out), 32'h55);
      check("pass_idx4", 32'(bus4.pad_idx), 2);

      reset_n = 1'b0;
      #1;
      check("async_idx4", 32'(bus4.pad_idx), 0);
      check("async_tmo4", 32'(bus4.timeout), 1);
      tick(1);
      reset_n = 1'b1;
      tick(1);

`ifdef MULTITAP_TH_FILTER_EN
      port_dir = 7'h3F;
      port_in  = 7'h40;
      tick(6);
      th_pulse();
      th_pulse();
      check("filt_base_idx4", 32'(bus4.pad_idx), 1);
      port_in[6] = 1'b0;
      tick(2);
      port_in[6] = 1'b1;
      tick(6);
      check("filt_glitch_idx4", 32'(bus4.pad_idx), 1);
      port_in[6] = 1'b0;
      tick(4);
      check("filt_hold_idx4", 32'(bus4.pad_idx), 1);
      tick(1);
      check("filt_adv_idx4", 32'(bus4.pad_idx), 2);
      port_in[6] = 1'b1;
      tick(6);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
